// File: rtl/mem_pkg.sv
//==============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the M-stage data-memory access controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [3:0] c_LD_NONE = 4'd0;
    localparam logic [3:0] c_LD_LW   = 4'd1;
    localparam logic [3:0] c_LD_LH   = 4'd2;
    localparam logic [3:0] c_LD_LHU  = 4'd3;
    localparam logic [3:0] c_LD_LB   = 4'd4;
    localparam logic [3:0] c_LD_LBU  = 4'd5;

    localparam logic [1:0] c_ST_NONE = 2'd0;
    localparam logic [1:0] c_ST_SW   = 2'd1;
    localparam logic [1:0] c_ST_SH   = 2'd2;
    localparam logic [1:0] c_ST_SB   = 2'd3;

    localparam logic [3:0] c_BE_WORD    = 4'b1111;
    localparam logic [3:0] c_BE_HALF_LO = 4'b0011;
    localparam logic [3:0] c_BE_HALF_HI = 4'b1100;
    localparam logic [3:0] c_BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= c_LD_LW) && (op <= c_LD_LBU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byteen_gen.sv
//==============================================================================
// Module      : mem_byteen_gen
// Description : Byte-enable, store-lane replication and alignment check.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_byteen_gen
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  loadop,
    input  logic [1:0]  storeop,
    input  logic [31:0] wdata_in,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        aligned
);

    // A store takes precedence over a simultaneously encoded load.
    always_comb begin
        byteen  = c_BE_WORD;
        wdata   = wdata_in;
        aligned = 1'b1;
        if (storeop != c_ST_NONE) begin
            case (storeop)
                c_ST_SH: begin
                    byteen  = addr_lo[1] ? c_BE_HALF_HI : c_BE_HALF_LO;
                    wdata   = {2{wdata_in[15:0]}};
                    aligned = ~addr_lo[0];
                end
                c_ST_SB: begin
                    byteen = c_BE_BYTE0 << addr_lo;
                    wdata  = {4{wdata_in[7:0]}};
                end
                default: aligned = (addr_lo == 2'b00);
            endcase
        end else begin
            case (loadop)
                c_LD_LW:           aligned = (addr_lo == 2'b00);
                c_LD_LH, c_LD_LHU: aligned = ~addr_lo[0];
                default:           aligned = 1'b1;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//==============================================================================
// Module      : mem_access_ctrl
// Description : M-stage load/store to request/grant/response bus bridge with stall.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ALUresult_M,
    input  logic [31:0]       WriteData_M,
    input  logic [3:0]        Loadop,
    input  logic [1:0]        Storeop,
    output logic              stall_mem,
    output logic              misalign,
    output logic [31:0]       MemOutput_pre,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_byteen,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_byteen;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;

    logic               w_acc_st;
    logic               w_acc;
    logic               w_aligned;
    logic [3:0]         w_byteen;
    logic [31:0]        w_wdata;
    logic               w_issue;
    logic               w_misalign;
    logic               w_capture;
    logic               w_stall;
    logic               w_req;

    mem_byteen_gen u_byteen_gen (
        .addr_lo  (ALUresult_M[1:0]),
        .loadop   (Loadop),
        .storeop  (Storeop),
        .wdata_in (WriteData_M),
        .byteen   (w_byteen),
        .wdata    (w_wdata),
        .aligned  (w_aligned)
    );

    assign w_acc_st = (Storeop != c_ST_NONE);
    assign w_acc    = w_acc_st | is_load(Loadop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_misalign  = 1'b0;
        w_capture   = 1'b0;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_aligned) begin
                        w_issue     = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (mem_gnt) begin
                    if (r_we) begin
                        w_state_nxt = S_DONE;
                    end else if (mem_rvalid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus fields are latched once at issue so they stay stable until grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_byteen <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_issue) begin
                r_we     <= w_acc_st;
                r_addr   <= {ALUresult_M[ADDR_W-1:2], 2'b00};
                r_byteen <= w_byteen;
                r_wdata  <= w_wdata;
            end
            if (w_misalign) begin
                r_rdata <= '0;
            end else if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign stall_mem     = w_stall;
    assign misalign      = w_misalign;
    assign mem_req       = w_req;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_byteen    = r_byteen;
    assign mem_wdata     = r_wdata;
    assign MemOutput_pre = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//==============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] ALUresult_M;
    logic [31:0] WriteData_M;
    logic [3:0]  Loadop;
    logic [1:0]  Storeop;
    logic        stall_mem;
    logic        misalign;
    logic [31:0] MemOutput_pre;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.ADDR_W(32)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .ALUresult_M   (ALUresult_M),
        .WriteData_M   (WriteData_M),
        .Loadop        (Loadop),
        .Storeop       (Storeop),
        .stall_mem     (stall_mem),
        .misalign      (misalign),
        .MemOutput_pre (MemOutput_pre),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_byteen    (mem_byteen),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, drive this cycle's inputs, let combinational outputs settle.
    task automatic cyc(input logic [3:0] ld, input logic [1:0] st, input logic [31:0] addr,
                       input logic [31:0] wd, input logic gnt, input logic rv,
                       input logic [31:0] rd);
        @(posedge clk);
        #1;
        Loadop      = ld;
        Storeop     = st;
        ALUresult_M = addr;
        WriteData_M = wd;
        mem_gnt     = gnt;
        mem_rvalid  = rv;
        mem_rdata   = rd;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        Loadop      = 4'd0;
        Storeop     = 2'd0;
        ALUresult_M = 32'd0;
        WriteData_M = 32'd0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        #1 reset = 1'b0;
        #2;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_byteen", {28'd0, mem_byteen}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", MemOutput_pre, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // sw 0x12345678 @0x100, immediate grant
        cyc(4'd0, 2'd1, 32'h100, 32'h12345678, 1'b1, 1'b0, 32'd0);
        chk("sw_det_stall", {31'd0, stall_mem}, 32'd1);
        chk("sw_det_req", {31'd0, mem_req}, 32'd0);
        cyc(4'd0, 2'd1, 32'h100, 32'h12345678, 1'b1, 1'b0, 32'd0);
        chk("sw_req", {31'd0, mem_req}, 32'd1);
        chk("sw_we", {31'd0, mem_we}, 32'd1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_byteen", {28'd0, mem_byteen}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'h12345678);
        chk("sw_req_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd0, 2'd1, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'd0);
        chk("sw_done_stall", {31'd0, stall_mem}, 32'd0);
        chk("sw_done_req", {31'd0, mem_req}, 32'd0);

        // sb 0xAB @0x203, grant after three waiting REQ cycles, back-to-back
        cyc(4'd0, 2'd3, 32'h203, 32'h000000AB, 1'b0, 1'b0, 32'd0);
        chk("sb_det_stall", {31'd0, stall_mem}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'd0, 2'd3, 32'h203, 32'h000000AB, 1'b0, 1'b0, 32'd0);
            chk("sb_wait_req", {31'd0, mem_req}, 32'd1);
            chk("sb_byteen", {28'd0, mem_byteen}, 32'h8);
            chk("sb_wdata", mem_wdata, 32'hABABABAB);
            chk("sb_addr", mem_addr, 32'h200);
            chk("sb_stall", {31'd0, stall_mem}, 32'd1);
        end
        cyc(4'd0, 2'd3, 32'h203, 32'h000000AB, 1'b1, 1'b0, 32'd0);
        chk("sb_gnt_req", {31'd0, mem_req}, 32'd1);
        chk("sb_gnt_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd0, 2'd3, 32'h203, 32'h000000AB, 1'b0, 1'b0, 32'd0);
        chk("sb_done_stall", {31'd0, stall_mem}, 32'd0);

        // lw @0x40, grant at first REQ cycle, rvalid two cycles later
        cyc(4'd1, 2'd0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lw_det_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd1, 2'd0, 32'h40, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("lw_req", {31'd0, mem_req}, 32'd1);
        chk("lw_we", {31'd0, mem_we}, 32'd0);
        chk("lw_addr", mem_addr, 32'h40);
        chk("lw_byteen", {28'd0, mem_byteen}, 32'hF);
        cyc(4'd1, 2'd0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lw_wait_req", {31'd0, mem_req}, 32'd0);
        chk("lw_wait_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd1, 2'd0, 32'h40, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("lw_wait2_req", {31'd0, mem_req}, 32'd0);
        chk("lw_wait2_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd1, 2'd0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lw_done_data", MemOutput_pre, 32'hDEADBEEF);
        chk("lw_done_stall", {31'd0, stall_mem}, 32'd0);

        // lh @0x41 misaligned
        cyc(4'd2, 2'd0, 32'h41, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lh_mis_pulse", {31'd0, misalign}, 32'd1);
        chk("lh_mis_stall", {31'd0, stall_mem}, 32'd0);
        chk("lh_mis_req", {31'd0, mem_req}, 32'd0);
        cyc(4'd0, 2'd0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lh_mis_clear", MemOutput_pre, 32'd0);
        chk("lh_mis_end", {31'd0, misalign}, 32'd0);
        chk("lh_mis_noreq", {31'd0, mem_req}, 32'd0);

        // sw @0x102 misaligned: store suppressed, bus registers untouched
        cyc(4'd0, 2'd1, 32'h102, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
        chk("sw_mis_pulse", {31'd0, misalign}, 32'd1);
        chk("sw_mis_stall", {31'd0, stall_mem}, 32'd0);
        cyc(4'd0, 2'd0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("sw_mis_addr", mem_addr, 32'h40);
        chk("sw_mis_noreq", {31'd0, mem_req}, 32'd0);

        // lbu @0x81, grant and rvalid together
        cyc(4'd5, 2'd0, 32'h81, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lbu_det_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd5, 2'd0, 32'h81, 32'd0, 1'b1, 1'b1, 32'h11223344);
        chk("lbu_addr", mem_addr, 32'h80);
        chk("lbu_byteen", {28'd0, mem_byteen}, 32'hF);
        cyc(4'd5, 2'd0, 32'h81, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("lbu_done_data", MemOutput_pre, 32'h11223344);
        chk("lbu_done_stall", {31'd0, stall_mem}, 32'd0);

        // lw @0x80, reset asserted in WAIT, stray rvalid after release
        cyc(4'd1, 2'd0, 32'h80, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(4'd1, 2'd0, 32'h80, 32'd0, 1'b1, 1'b0, 32'd0);
        cyc(4'd1, 2'd0, 32'h80, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rw_wait_stall", {31'd0, stall_mem}, 32'd1);
        reset  = 1'b0;
        Loadop = 4'd0;
        #1;
        chk("rw_req", {31'd0, mem_req}, 32'd0);
        chk("rw_stall", {31'd0, stall_mem}, 32'd0);
        chk("rw_data", MemOutput_pre, 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        #1;
        chk("rw_rel_stall", {31'd0, stall_mem}, 32'd0);
        cyc(4'd0, 2'd0, 32'h0, 32'd0, 1'b0, 1'b1, 32'hCAFEF00D);
        chk("rw_stray_data", MemOutput_pre, 32'd0);
        chk("rw_stray_req", {31'd0, mem_req}, 32'd0);
        cyc(4'd0, 2'd0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rw_stray_data2", MemOutput_pre, 32'd0);

        // Reset during REQ drops mem_req without waiting for a clock
        cyc(4'd0, 2'd1, 32'h300, 32'h1, 1'b0, 1'b0, 32'd0);
        cyc(4'd0, 2'd1, 32'h300, 32'h1, 1'b0, 1'b0, 32'd0);
        chk("rr_req_before", {31'd0, mem_req}, 32'd1);
        reset   = 1'b0;
        Storeop = 2'd0;
        #1;
        chk("rr_req_drop", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // lw @0x10 with gnt+rvalid in REQ, then sh @0x2 with no gap
        cyc(4'd1, 2'd0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h99999999);
        chk("bb_det_stall", {31'd0, stall_mem}, 32'd1);
        cyc(4'd1, 2'd0, 32'h10, 32'd0, 1'b1, 1'b1, 32'h55AA55AA);
        chk("bb_req", {31'd0, mem_req}, 32'd1);
        chk("bb_idle_rv_ign", MemOutput_pre, 32'd0);
        cyc(4'd1, 2'd0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("bb_done_data", MemOutput_pre, 32'h55AA55AA);
        chk("bb_done_stall", {31'd0, stall_mem}, 32'd0);
        chk("bb_done_req", {31'd0, mem_req}, 32'd0);
        cyc(4'd0, 2'd2, 32'h2, 32'h0000BEEF, 1'b0, 1'b0, 32'd0);
        chk("sh_det_stall", {31'd0, stall_mem}, 32'd1);
        chk("sh_hold_data", MemOutput_pre, 32'h55AA55AA);
        cyc(4'd0, 2'd2, 32'h2, 32'h0000BEEF, 1'b1, 1'b0, 32'd0);
        chk("sh_req", {31'd0, mem_req}, 32'd1);
        chk("sh_byteen", {28'd0, mem_byteen}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        chk("sh_addr", mem_addr, 32'h0);
        chk("sh_we", {31'd0, mem_we}, 32'd1);
        cyc(4'd0, 2'd2, 32'h2, 32'h0000BEEF, 1'b0, 1'b0, 32'd0);
        chk("sh_done_stall", {31'd0, stall_mem}, 32'd0);
        cyc(4'd0, 2'd0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("sh_idle_req", {31'd0, mem_req}, 32'd0);
        chk("sh_idle_stall", {31'd0, stall_mem}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

M-stage data-memory access controller for the P6 pipelined MIPS core. It sits directly upstream of `LoadMemData`. It turns the M-stage load/store request into a registered request/grant/response transaction on a variable-latency data-memory bus, and stalls the pipeline while the access is outstanding. It then presents the raw aligned word `MemOutput_pre` to `LoadMemData`, which performs byte/half extraction and extension.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ALUresult_M`  in  32  M-stage byte address.
- `WriteData_M`  in  32  M-stage store data (rt value).
- `Loadop`  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu; other values treated as none.
- `Storeop`  in  2  0 none, 1 sw, 2 sh, 3 sb.
- `stall_mem`  out  1  freezes F/D/E/M, bubbles W.
- `misalign`  out  1  one-cycle pulse on misaligned access.
- `MemOutput_pre`  out  32  captured read word, to `LoadMemData`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 store, 0 load.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_byteen`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- `acc` = (`Loadop` in 1..5 or `Storeop`≠0), evaluated only in IDLE. Load and store are never both set; if both are set, the store wins.
- Alignment rules:
  - lw/sw need `addr[1:0]`=0.
  - lh/lhu/sh need `addr[0]`=0.
- IDLE, misaligned `acc`:
  - `misalign`=1 for one cycle; no bus request.
  - `MemOutput_pre` is set to 0 at the next edge; the store is suppressed.
  - `stall_mem`=0; stay in IDLE.
- IDLE, aligned `acc`:
  - Register `mem_we`, `mem_addr`, `mem_byteen`, `mem_wdata`; go to REQ.
- REQ:
  - `mem_req`=1, with all bus outputs stable until `mem_gnt`.
  - On `gnt`:
    - store → DONE.
    - load with `mem_rvalid` in the same cycle → capture `mem_rdata`, go to DONE.
    - load without `mem_rvalid` → WAIT.
- WAIT: `mem_req`=0; on `mem_rvalid`, capture `mem_rdata` into `MemOutput_pre` and go to DONE.
- DONE: `stall_mem`=0 and the pipeline advances; go to IDLE unconditionally.
- `stall_mem` = (IDLE & aligned `acc`) | REQ | WAIT. This is combinational, so it is asserted in the same cycle the instruction enters M.
- `mem_rvalid` is ignored in IDLE, DONE, and in REQ without `gnt`.
- Byte enables:
  - Loads and sw: 1111.
  - sh: `addr[1]` ? 1100 : 0011.
  - sb: 0001 << `addr[1:0]`.
- Store data lanes:
  - sw: passthrough.
  - sh: `{2{wd[15:0]}}`.
  - sb: `{4{wd[7:0]}}`.
- `MemOutput_pre` holds its value until the next capture.

## Timing
- Reset (async, active-low) gives:
  - state IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_byteen`=0, `mem_wdata`=0.
  - `MemOutput_pre`=0, `misalign`=0.
  - `stall_mem` follows the combinational rule.
- Reset mid-REQ/WAIT: `mem_req` drops immediately; a late `mem_rvalid` after release is ignored.
- Minimum M occupancy with an immediate `gnt` (and same-cycle `rvalid` for loads) is 3 cycles:
  - detect cycle, stalled.
  - REQ cycle, stalled.
  - DONE cycle, not stalled.
- Each cycle of `gnt` delay adds 1 cycle; each cycle of `rvalid` delay after `gnt` adds 1 cycle.
- `MemOutput_pre` is valid from the DONE cycle onward. It is sampled by the M/W register at the DONE→IDLE edge.
- Back-to-back accesses: the instruction after DONE is detected in the following IDLE cycle, with no lost cycle.

## Structure
- Package `mem_pkg` holds:
  - Loadop/Storeop encoding constants.
  - the 2-bit state enum (IDLE=0, REQ=1, WAIT=2, DONE=3).
  - the byte-enable constants.
- Sub-module `mem_byteen_gen` (combinational) takes `addr[1:0]`, `Storeop`, and `WriteData_M`. It produces `byteen`, `wdata`, and `aligned`. It is shared with the `Loadop` alignment check.
- The FSM and bus registers live in `mem_access_ctrl`.

## Test plan
- sw 0x12345678 @0x100, `gnt` immediate:
  - REQ with `we`=1, `addr`=0x100, `byteen`=1111.
  - `stall_mem` high for 2 cycles, DONE on cycle 3.
- sb 0xAB @0x203, `gnt` after 3 cycles:
  - `byteen`=1000, `wdata`=0xABABABAB, `addr`=0x200.
  - bus outputs stable across the wait; stall for 5 cycles.
- lw @0x40, `gnt` at cycle 1, `rvalid` 2 cycles later with 0xDEADBEEF:
  - WAIT is entered.
  - `MemOutput_pre`=0xDEADBEEF in DONE.
  - `mem_req`=0 during WAIT.
- lh @0x41:
  - `misalign` pulse, no `mem_req`, `stall_mem`=0.
  - `MemOutput_pre`=0 next cycle.
- `reset` asserted in WAIT, then `rvalid` after release:
  - state IDLE, `mem_req`=0, `MemOutput_pre`=0.
  - the stray `rvalid` is ignored.
- Load with `gnt` and `rvalid` in the same REQ cycle, followed immediately by sh @0x2:
  - direct REQ→DONE for the load.
  - the sh request issues with `byteen`=1100 with no gap cycle.
